// File: rtl/bus_host_arbiter_2_if.sv
// Single-master bus port: request side (address/write data/mask/wen/ren) and
// response side (data_read/ready). Used for both host masters and the hub link.
interface bus_host_arbiter_2_if;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [3:0]  write_mask;
  logic        wen;
  logic        ren;
  logic [31:0] data_read;
  logic        ready;

  modport master (output address, data_write, write_mask, wen, ren,
                  input  data_read, ready);
  modport slave  (input  address, data_write, write_mask, wen, ren,
                  output data_read, ready);
endinterface

// File: rtl/bus_host_arbiter_2.sv
// Two-master round-robin arbiter in front of the bus_hub_2 host port; grants whole
// transactions. Optional ready timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_host_arbiter_2
`ifdef BUS_ARB_TIMEOUT_EN
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
)
`endif
(
  input  logic                         clk,
  input  logic                         rst,
  bus_host_arbiter_2_if.slave          h0,
  bus_host_arbiter_2_if.slave          h1,
  bus_host_arbiter_2_if.master         bus,
  output logic [1:0]                   grant,
  output logic                         timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   rr_last_q, rr_last_d;   // last master served; 1 at reset so h0 wins the first tie

  logic req0, req1, own, own_idx, own_req;
  logic rsp_ready;
  logic [31:0] rsp_data;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
`endif

  assign req0 = h0.wen | h0.ren;
  assign req1 = h1.wen | h1.ren;

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    rr_last_d      = rr_last_q;
    grant          = 2'b00;
    bus.address    = '0;
    bus.data_write = '0;
    bus.write_mask = '0;
    bus.wen        = 1'b0;
    bus.ren        = 1'b0;
    rsp_ready      = 1'b0;
    rsp_data       = '0;
    own            = (state_q != IDLE);
    own_idx        = (state_q == OWN1);
    own_req        = own_idx ? req1 : req0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d          = '0;
    terr_d         = terr_q;
`endif

    if (!own) begin
      if (req0 && (!req1 || rr_last_q)) state_d = OWN0;
      else if (req1)                    state_d = OWN1;
    end else begin
      grant          = own_idx ? 2'b10 : 2'b01;
      bus.address    = own_idx ? h1.address    : h0.address;
      bus.data_write = own_idx ? h1.data_write : h0.data_write;
      bus.write_mask = own_idx ? h1.write_mask : h0.write_mask;
      bus.wen        = own_idx ? h1.wen        : h0.wen;
      bus.ren        = own_idx ? h1.ren        : h0.ren;
      rsp_ready      = bus.ready;
      rsp_data       = bus.data_read;

      // Completion and abort both release the bus through IDLE.
      if (bus.ready || !own_req) begin
        state_d   = IDLE;
        rr_last_d = own_idx;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        rsp_ready = 1'b1;
        rsp_data  = TIMEOUT_RDATA;
        state_d   = IDLE;
        rr_last_d = own_idx;
        terr_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end

  assign h0.ready     = own & ~own_idx & rsp_ready;
  assign h1.ready     = own &  own_idx & rsp_ready;
  assign h0.data_read = (own & ~own_idx) ? rsp_data : 32'h0;
  assign h1.data_read = (own &  own_idx) ? rsp_data : 32'h0;

`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
`endif
    end
  end

endmodule
